// File: rtl/hangman_pkg.sv
// Shared types for the hangman round engine: FSM state encoding, guess
// result classification and width helpers for derived parameters.
package hangman_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    HIT,
    MISS,
    DUP
  } result_t;

  // Bits needed to hold the values 0..max_value inclusive.
  function automatic int unsigned width_for(input int unsigned max_value);
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/hangman_timer.sv
// Loadable down-counter with tick enable, hold and zero flag.
// A tick seen while held is remembered and applied once counting resumes.
module hangman_timer
  import hangman_pkg::*;
#(
  parameter int unsigned LIMIT = 60,
  parameter int unsigned W     = width_for(LIMIT)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         load,
  input  logic         run,
  input  logic         hold,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         expire
);

  logic pend_q;
  logic dec;

  assign dec    = run & (tick | pend_q);
  assign zero   = (count == '0);
  assign expire = dec & (count == W'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      pend_q <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      pend_q <= 1'b0;
    end else if (load) begin
      count  <= W'(LIMIT);
      pend_q <= 1'b0;
    end else if (hold) begin
      pend_q <= pend_q | tick;
    end else if (run) begin
      if (dec && !zero) count <= count - W'(1);
      // a fresh tick coinciding with a deferred one leaves one still pending
      pend_q <= tick & pend_q;
    end else begin
      pend_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hangman_round_engine.sv
// One hangman round: word load, timed guessing with a one-cycle compare
// stage, win/lose resolution and saturating scores for both players.
module hangman_round_engine
  import hangman_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned CHAR_W     = 5,
  parameter int unsigned MAX_MISS   = 9,
  parameter int unsigned TIME_LIMIT = 60,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned LEN_W      = width_for(MAX_LEN),
  parameter int unsigned MISS_W     = width_for(MAX_MISS),
  parameter int unsigned TIME_W     = width_for(TIME_LIMIT)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               new_round,
  input  logic               load_valid,
  input  logic [CHAR_W-1:0]  load_char,
  input  logic               load_done,
  input  logic               guess_valid,
  input  logic [CHAR_W-1:0]  guess_char,
  input  logic               tick,
  output logic [2:0]         state,
  output logic [LEN_W-1:0]   word_len,
  output logic [MAX_LEN-1:0] revealed,
  output logic [MISS_W-1:0]  miss_cnt,
  output logic [TIME_W-1:0]  time_left,
  output logic               guess_hit,
  output logic               guess_miss,
  output logic               guess_dup,
  output logic               round_win,
  output logic               round_lose,
  output logic [SCORE_W-1:0] setter_score,
  output logic [SCORE_W-1:0] guesser_score
);

  state_t              state_q, state_d;
  logic [CHAR_W-1:0]   word [MAX_LEN];
  logic [CHAR_W-1:0]   guess_q;
  logic [MAX_LEN-1:0]  len_mask, match, fresh;
  logic [MISS_W-1:0]   miss_next;
  result_t             result;
  logic                win, miss_lose, timeout, go_play;
  logic                in_load, in_play, in_check;
  logic                t_zero, t_expire;

  hangman_timer #(
    .LIMIT (TIME_LIMIT),
    .W     (TIME_W)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (new_round),
    .load   (go_play),
    .run    (in_play),
    .hold   (in_check),
    .tick   (tick),
    .count  (time_left),
    .zero   (t_zero),
    .expire (t_expire)
  );

  // Parallel compare of the registered guess against every loaded position.
  always_comb begin
    len_mask = '0;
    match    = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < word_len);
      match[i]    = len_mask[i] && (word[i] == guess_q);
    end
    fresh     = match & ~revealed;
    miss_next = miss_cnt + MISS_W'(1);
    if (fresh != '0)      result = HIT;
    else if (match != '0) result = DUP;
    else                  result = MISS;
    win       = (((revealed | fresh) & len_mask) == len_mask);
    miss_lose = (miss_next == MISS_W'(MAX_MISS));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Expiry is checked before the guess, so a guess on the final tick is dropped.
  always_comb begin
    state_d = state_q;
    if (new_round) begin
      state_d = LOAD;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        LOAD:    if (go_play) state_d = PLAY;
        PLAY:    if (timeout) state_d = DONE;
                 else if (guess_valid) state_d = CHECK;
        CHECK:   if ((result == HIT && win) || (result == MISS && miss_lose))
                   state_d = DONE;
                 else
                   state_d = PLAY;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    state    = state_q;
    in_load  = (state_q == LOAD);
    in_play  = (state_q == PLAY);
    in_check = (state_q == CHECK);
    go_play  = in_load && load_done && (word_len != '0) && !new_round;
    timeout  = in_play && (t_zero || t_expire);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) word[i] <= '0;
      guess_q       <= '0;
      word_len      <= '0;
      revealed      <= '0;
      miss_cnt      <= '0;
      guess_hit     <= 1'b0;
      guess_miss    <= 1'b0;
      guess_dup     <= 1'b0;
      round_win     <= 1'b0;
      round_lose    <= 1'b0;
      setter_score  <= '0;
      guesser_score <= '0;
    end else begin
      guess_hit  <= 1'b0;
      guess_miss <= 1'b0;
      guess_dup  <= 1'b0;
      if (new_round) begin
        word_len   <= '0;
        revealed   <= '0;
        miss_cnt   <= '0;
        round_win  <= 1'b0;
        round_lose <= 1'b0;
      end else begin
        case (state_q)
          LOAD: begin
            if (load_valid && (word_len < LEN_W'(MAX_LEN))) begin
              for (int unsigned i = 0; i < MAX_LEN; i++)
                if (LEN_W'(i) == word_len) word[i] <= load_char;
              word_len <= word_len + LEN_W'(1);
            end
            if (go_play) begin
              revealed <= '0;
              miss_cnt <= '0;
            end
          end
          PLAY: begin
            if (timeout) begin
              round_lose <= 1'b1;
              if (setter_score != '1) setter_score <= setter_score + SCORE_W'(1);
            end else if (guess_valid) begin
              guess_q <= guess_char;
            end
          end
          CHECK: begin
            unique case (result)
              HIT: begin
                revealed  <= revealed | fresh;
                guess_hit <= 1'b1;
                if (win) begin
                  round_win <= 1'b1;
                  if (guesser_score != '1) guesser_score <= guesser_score + SCORE_W'(1);
                end
              end
              DUP: guess_dup <= 1'b1;
              default: begin
                miss_cnt   <= miss_next;
                guess_miss <= 1'b1;
                if (miss_lose) begin
                  round_lose <= 1'b1;
                  if (setter_score != '1) setter_score <= setter_score + SCORE_W'(1);
                end
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hangman_round_engine.sv
// Bench for hangman_round_engine: table-driven guess sequences with a
// scoreboard of expected guess results and their due cycle.
module tb_hangman_round_engine;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CHAR_W  = 5;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned MISS_W  = 4;
  localparam int unsigned TIME_W  = 2;
  localparam int unsigned SCORE_W = 8;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_PLAY = 3'd2, S_DONE = 3'd4;
  localparam logic [2:0] R_HIT = 3'b100, R_MISS = 3'b010, R_DUP = 3'b001;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               new_round = 1'b0, load_valid = 1'b0, load_done = 1'b0;
  logic               guess_valid = 1'b0, tick = 1'b0;
  logic [CHAR_W-1:0]  load_char = '0, guess_char = '0;
  logic [2:0]         state;
  logic [LEN_W-1:0]   word_len;
  logic [MAX_LEN-1:0] revealed;
  logic [MISS_W-1:0]  miss_cnt;
  logic [TIME_W-1:0]  time_left;
  logic               guess_hit, guess_miss, guess_dup, round_win, round_lose;
  logic [SCORE_W-1:0] setter_score, guesser_score;

  hangman_round_engine #(.TIME_LIMIT(3)) dut (
    .clk(clk), .resetn(resetn), .new_round(new_round),
    .load_valid(load_valid), .load_char(load_char), .load_done(load_done),
    .guess_valid(guess_valid), .guess_char(guess_char), .tick(tick),
    .state(state), .word_len(word_len), .revealed(revealed), .miss_cnt(miss_cnt),
    .time_left(time_left), .guess_hit(guess_hit), .guess_miss(guess_miss),
    .guess_dup(guess_dup), .round_win(round_win), .round_lose(round_lose),
    .setter_score(setter_score), .guesser_score(guesser_score)
  );

  always #5 clk = ~clk;

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [2:0]  res;
    int unsigned due;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [CHAR_W-1:0]  c;
    logic [2:0]         res;
    logic [MAX_LEN-1:0] rev;
    int unsigned        miss;
    logic [2:0]         st;
  } vec_t;
  vec_t vt[4];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CHAR_W-1:0] code(input byte b);
    return CHAR_W'(int'(b) - 64);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round();
    new_round = 1'b1;
    step();
    new_round = 1'b0;
  endtask

  task automatic load_word(input string s, input bit finish);
    for (int i = 0; i < s.len(); i++) begin
      load_char  = code(s[i]);
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
    end
    if (finish) begin
      load_done = 1'b1;
      step();
      load_done = 1'b0;
    end
  endtask

  task automatic wait_pulse();
    bit   seen;
    sb_t  e;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step();
      tick = 1'b0;
      if (guess_hit | guess_miss | guess_dup) begin
        seen = 1'b1;
        e = sbq.pop_front();
        chk("guess_result", {29'd0, guess_hit, guess_miss, guess_dup}, {29'd0, e.res});
        chk("guess_latency", cyc_n, e.due);
      end
    end
    if (!seen) begin
      e = sbq.pop_front();
      chk("guess_pulse_timeout", 32'd0, {29'd0, e.res});
    end
  endtask

  task automatic do_guess(input logic [CHAR_W-1:0] c, input logic [2:0] exp_res, input bit tk);
    guess_char  = c;
    guess_valid = 1'b1;
    sbq.push_back('{exp_res, cyc_n + 2});
    step();
    guess_valid = 1'b0;
    tick = tk;
    wait_pulse();
  endtask

  task automatic ignored_guess(input logic [CHAR_W-1:0] c, input bit tk);
    int seen;
    seen = 0;
    guess_char  = c;
    guess_valid = 1'b1;
    tick = tk;
    step();
    guess_valid = 1'b0;
    tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (guess_hit | guess_miss | guess_dup) seen++;
      step();
    end
    chk("no_guess_pulse", seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{code("B"), R_HIT,  16'h0005, 0, S_PLAY};
    vt[1] = '{code("B"), R_DUP,  16'h0005, 0, S_PLAY};
    vt[2] = '{code("Q"), R_MISS, 16'h0005, 1, S_PLAY};
    vt[3] = '{code("O"), R_HIT,  16'h0007, 1, S_DONE};

    #12;
    chk("reset_state", state, S_IDLE);
    chk("reset_outputs", {word_len, revealed, miss_cnt, time_left},  '0);
    chk("reset_flags", {guess_hit, guess_miss, guess_dup, round_win, round_lose}, '0);
    chk("reset_scores", {setter_score, guesser_score}, '0);
    resetn = 1'b1;
    step();
    step();

    // CAT: single hit in the middle position
    start_round();
    chk("cat_load_state", state, S_LOAD);
    load_word("CAT", 1'b1);
    chk("cat_word_len", word_len, 3);
    chk("cat_play_state", state, S_PLAY);
    chk("cat_time_left", time_left, 3);
    do_guess(code("A"), R_HIT, 1'b0);
    chk("cat_revealed", revealed, 16'h0002);
    chk("cat_miss", miss_cnt, 0);

    // BOB: hit, duplicate, miss, winning hit
    start_round();
    chk("bob_cleared", {word_len, revealed, miss_cnt}, '0);
    load_word("BOB", 1'b1);
    foreach (vt[i]) begin
      do_guess(vt[i].c, vt[i].res, 1'b0);
      chk("bob_revealed", revealed, vt[i].rev);
      chk("bob_miss", miss_cnt, vt[i].miss);
      chk("bob_state", state, vt[i].st);
    end
    chk("bob_win", {round_win, round_lose}, 2'b10);
    chk("bob_guesser_score", guesser_score, 1);
    chk("bob_setter_score", setter_score, 0);

    // new_round in DONE keeps scores, clears the rest
    start_round();
    chk("nr_state", state, S_LOAD);
    chk("nr_scores", {setter_score, guesser_score}, 16'h0001);
    chk("nr_cleared", {round_win, round_lose, word_len, revealed, miss_cnt, time_left}, '0);

    // Z: nine distinct misses lose the round
    load_word("Z", 1'b1);
    for (int i = 0; i < 9; i++) begin
      do_guess(CHAR_W'(i + 1), R_MISS, 1'b0);
      chk("z_miss_cnt", miss_cnt, i + 1);
    end
    chk("z_state", state, S_DONE);
    chk("z_lose", {round_win, round_lose}, 2'b01);
    chk("z_setter_score", setter_score, 1);
    ignored_guess(code("J"), 1'b0);
    chk("z_miss_held", miss_cnt, 9);

    // DOG: tick deferred across CHECK, then timeout beats a same-cycle guess
    start_round();
    load_word("DOG", 1'b1);
    do_guess(code("D"), R_HIT, 1'b1);
    chk("dog_time_in_check", time_left, 3);
    step();
    chk("dog_deferred_tick", time_left, 2);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("dog_tick", time_left, 1);
    ignored_guess(code("O"), 1'b1);
    chk("dog_state", state, S_DONE);
    chk("dog_lose", {round_win, round_lose}, 2'b01);
    chk("dog_time_zero", time_left, 0);
    chk("dog_revealed", revealed, 16'h0001);
    chk("dog_setter_score", setter_score, 2);

    // overflowing load: 18 strobes, first character must survive
    start_round();
    load_word("ABBBBBBBBBBBBBBBBB", 1'b0);
    chk("ovf_word_len", word_len, MAX_LEN);
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    chk("ovf_play", state, S_PLAY);
    do_guess(code("A"), R_HIT, 1'b0);
    chk("ovf_rev_a", revealed, 16'h0001);
    do_guess(code("B"), R_HIT, 1'b0);
    chk("ovf_rev_all", revealed, 16'hFFFF);
    chk("ovf_win", {round_win, state}, {1'b1, S_DONE});
    chk("ovf_guesser_score", guesser_score, 2);

    // empty word: load_done ignored
    start_round();
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    step();
    chk("empty_stays_load", state, S_LOAD);

    // asynchronous reset mid-play
    load_word("CAT", 1'b1);
    do_guess(code("C"), R_HIT, 1'b0);
    chk("rst_pre_revealed", revealed, 16'h0001);
    resetn = 1'b0;
    #1;
    chk("rst_state", state, S_IDLE);
    chk("rst_outputs", {word_len, revealed, miss_cnt, time_left}, '0);
    chk("rst_flags", {guess_hit, guess_miss, guess_dup, round_win, round_lose}, '0);
    chk("rst_scores", {setter_score, guesser_score}, '0);
    step();
    resetn = 1'b1;
    step();

    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
